// File: rtl/mips_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_if_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 32'hFC00_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } if_state_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_perf_counter.sv
// Fetch/stall event counters for the fetch stage; instantiated only when IF_PERF_CNT_EN is defined.
module if_perf_counter
  import mips_if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        stall_en,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    fetch_d = fetch_en ? fetch_q + 32'd1 : fetch_q;
    stall_d = stall_en ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end

  assign fetch_count = fetch_q;
  assign stall_count = stall_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register with valid/ready, redirect flush, halt on sentinel.
// Optional perf counters (fetch_count/stall_count) are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit
  import mips_if_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);
  if_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  idpc_q, idpc_d;
  logic               halted_q, halted_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    idpc_d   = idpc_q;
    halted_d = halted_q;
    case (state_q)
      FETCH: begin
        // Redirect wins over capture: the word at the old pc is dropped.
        if (br_taken) begin
          pc_d    = align_word(br_target);
          valid_d = 1'b0;
        end else if (!valid_q || id_ready) begin
          instr_d = imem_instr;
          idpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          if (imem_instr == HALT_WORD) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
        end
      end
      HALT: begin
        if (valid_q && id_ready) valid_d = 1'b0;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= align_word(RESET_PC);
      valid_q  <= 1'b0;
      instr_q  <= '0;
      idpc_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      idpc_q   <= idpc_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc       = idpc_q;
  assign id_pc_plus4 = idpc_q + 32'd4;
  assign halted      = halted_q;

`ifdef IF_PERF_CNT_EN
  logic fetch_en, stall_en;
  assign fetch_en = (state_q == FETCH) && !br_taken && (!valid_q || id_ready);
  assign stall_en = (state_q == FETCH) && valid_q && !id_ready;

  if_perf_counter u_perf (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall_en    (stall_en),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );
`endif
endmodule
